// File: rtl/braun_mul_seq.sv
// rtl/braun_mul_seq.sv - byte-serial operand/command sequencer for the 8x8 Braun array multiplier
//
// Collects operand A (with a command) and operand B from an 8-bit pin bus.
// Presents both to the external combinational array and waits MUL_LAT cycles
// for it to settle. Then captures the product, or a running 16-bit
// multiply-accumulate, and returns it as two bytes, low byte first.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_din, i_din_valid      operand/command byte bus and its strobe
//   i_cmd                   00 MUL, 01 MAC, 10 CLR, 11 reserved (sampled with A)
//   o_mul_a, o_mul_b        registered operands to the array
//   i_mul_p                 16-bit product from the array
//   o_dout, o_dout_valid    result byte stream
//   i_dout_ready            consumer accept
//   o_busy                  high whenever a transaction is in flight
//   o_ovf                   sticky accumulator carry-out
module braun_mul_seq #(
    parameter int MUL_LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_din,
    input  logic        i_din_valid,
    input  logic [1:0]  i_cmd,
    output logic [7:0]  o_mul_a,
    output logic [7:0]  o_mul_b,
    input  logic [15:0] i_mul_p,
    output logic [7:0]  o_dout,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    output logic        o_busy,
    output logic        o_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_B,
        S_WAIT,
        S_OUT_LO,
        S_OUT_HI
    } state_t;

    localparam logic [1:0] CMD_MUL = 2'b00;
    localparam logic [1:0] CMD_MAC = 2'b01;
    localparam logic [1:0] CMD_CLR = 2'b10;

    // The counter is loaded on the B edge; capture happens when it reaches
    // zero, so the array sees exactly MUL_LAT full cycles of stable operands.
    localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_op_mac;
    logic [3:0]  r_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_res;
    logic        r_ovf;
    logic [7:0]  r_mul_a;
    logic [7:0]  r_mul_b;

    logic        w_load_a;
    logic        w_load_b;
    logic        w_clr;
    logic        w_capture;
    logic        w_cnt_dec;
    logic [7:0]  w_dout;
    logic        w_dout_valid;
    logic [16:0] w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_mul_p};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_clr        = 1'b0;
        w_capture    = 1'b0;
        w_cnt_dec    = 1'b0;
        w_dout       = 8'h00;
        w_dout_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_din_valid) begin
                    if (i_cmd == CMD_MUL || i_cmd == CMD_MAC) begin
                        w_load_a    = 1'b1;
                        w_state_nxt = S_LOAD_B;
                    end else if (i_cmd == CMD_CLR) begin
                        w_clr = 1'b1;
                    end
                    // reserved command: byte is dropped
                end
            end
            S_LOAD_B: begin
                if (i_din_valid) begin
                    w_load_b    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_OUT_LO;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_OUT_LO: begin
                w_dout       = r_res[7:0];
                w_dout_valid = 1'b1;
                if (i_dout_ready) begin
                    w_state_nxt = S_OUT_HI;
                end
            end
            S_OUT_HI: begin
                w_dout       = r_res[15:8];
                w_dout_valid = 1'b1;
                if (i_dout_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op_mac <= 1'b0;
            r_cnt    <= 4'd0;
            r_acc    <= 16'h0000;
            r_res    <= 16'h0000;
            r_ovf    <= 1'b0;
            r_mul_a  <= 8'h00;
            r_mul_b  <= 8'h00;
        end else begin
            if (w_load_a) begin
                r_mul_a  <= i_din;
                r_op_mac <= i_cmd[0];
            end
            if (w_clr) begin
                r_acc <= 16'h0000;
                r_ovf <= 1'b0;
            end
            if (w_load_b) begin
                r_mul_b <= i_din;
                r_cnt   <= LAT_M1;
            end
            if (w_cnt_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                if (r_op_mac) begin
                    r_acc <= w_sum[15:0];
                    r_res <= w_sum[15:0];
                    r_ovf <= r_ovf | w_sum[16];
                end else begin
                    r_res <= i_mul_p;
                end
            end
        end
    end

    assign o_mul_a      = r_mul_a;
    assign o_mul_b      = r_mul_b;
    assign o_dout       = w_dout;
    assign o_dout_valid = w_dout_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_braun_mul_seq.sv
// tb/tb_braun_mul_seq.sv - self-checking bench for braun_mul_seq
module tb_braun_mul_seq;

    localparam int NDUT = 4;
    int lat_tab[NDUT] = '{2, 1, 4, 15};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        dout_ready = 1'b1;

    logic [7:0]  mul_a [NDUT];
    logic [7:0]  mul_b [NDUT];
    logic [15:0] mul_p [NDUT];
    logic [7:0]  dout  [NDUT];
    logic        dv    [NDUT];
    logic        busy  [NDUT];
    logic        ovf   [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 15;
        assign mul_p[g] = {8'h00, mul_a[g]} * {8'h00, mul_b[g]};
        braun_mul_seq #(.MUL_LAT(LAT)) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_din        (din),
            .i_din_valid  (din_valid),
            .i_cmd        (cmd),
            .o_mul_a      (mul_a[g]),
            .o_mul_b      (mul_b[g]),
            .i_mul_p      (mul_p[g]),
            .o_dout       (dout[g]),
            .o_dout_valid (dv[g]),
            .i_dout_ready (dout_ready),
            .o_busy       (busy[g]),
            .o_ovf        (ovf[g])
        );
    end

    int n_pass = 0;
    int n_total = 0;

    // reference model: accumulator and sticky carry as plain arithmetic
    int unsigned m_acc = 0;
    bit          m_ovf = 1'b0;

    function automatic logic [15:0] model_step(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        int unsigned s;
        p = int'(a) * int'(b);
        if (c == 2'b10) begin
            m_acc = 0;
            m_ovf = 1'b0;
            return 16'h0000;
        end
        if (c == 2'b00) return 16'(p);
        s = m_acc + p;
        if (s >= 65536) m_ovf = 1'b1;
        m_acc = s % 65536;
        return 16'(m_acc);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cmd(input logic [1:0] c, input logic [7:0] d);
        din = d; cmd = c; din_valid = 1'b1;
        tick;
        din_valid = 1'b0; din = 8'h00; cmd = 2'b00;
    endtask

    // full transaction on DUT 0 with ready held high
    task automatic do_txn(input string nm, input logic [1:0] c, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_res);
        int lat;
        logic [7:0] lo;
        logic [7:0] hi;
        dout_ready = 1'b1;
        pulse_cmd(c, a);
        din = b; din_valid = 1'b1;
        tick;
        din_valid = 1'b0; din = 8'h00;
        lat = 0;
        while (!dv[0] && lat < 40) begin
            tick;
            lat++;
        end
        chk({nm, " latency"}, lat, 2);
        lo = dout[0];
        tick;
        chk({nm, " hi valid"}, {31'b0, dv[0]}, 1);
        hi = dout[0];
        chk({nm, " result"}, {16'h0, hi, lo}, {16'h0, exp_res});
        tick;
        chk({nm, " idle after"}, {30'b0, dv[0], busy[0]}, 0);
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t tab[10];

    initial begin
        int lat;
        logic seen;
        int first [NDUT];
        logic [7:0] lo [NDUT];
        logic [7:0] hi [NDUT];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [1:0] rc;
        logic [15:0] er;

        tab[0] = '{2'b00, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
        tab[1] = '{2'b10, 8'h00, 8'h00, 16'h0000, 1'b0};
        tab[2] = '{2'b01, 8'h10, 8'h10, 16'h0100, 1'b0};
        tab[3] = '{2'b01, 8'h80, 8'h80, 16'h4100, 1'b0};
        tab[4] = '{2'b10, 8'h00, 8'h00, 16'h0000, 1'b0};
        tab[5] = '{2'b01, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
        tab[6] = '{2'b01, 8'hFF, 8'hFF, 16'hFC02, 1'b1};
        tab[7] = '{2'b00, 8'h02, 8'h03, 16'h0006, 1'b1};
        tab[8] = '{2'b10, 8'h00, 8'h00, 16'h0000, 1'b0};
        tab[9] = '{2'b11, 8'h5A, 8'h00, 16'h0000, 1'b0};

        // reset state
        tick;
        tick;
        chk("reset outputs", {dout[0], 5'b0, dv[0], busy[0], ovf[0], mul_a[0], mul_b[0]}, 32'h0);
        rst = 1'b0;
        tick;

        // table vectors
        for (int i = 0; i < 10; i++) begin
            if (tab[i].cmd[1]) begin
                pulse_cmd(tab[i].cmd, tab[i].a);
                seen = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    seen = seen | dv[0] | busy[0];
                    tick;
                end
                chk($sformatf("vec%0d no output", i), {31'b0, seen}, 0);
            end else begin
                do_txn($sformatf("vec%0d", i), tab[i].cmd, tab[i].a, tab[i].b, tab[i].exp_res);
            end
            chk($sformatf("vec%0d ovf", i), {31'b0, ovf[0]}, {31'b0, tab[i].exp_ovf});
        end

        // randomized MUL/MAC/CLR sequence against the model
        m_acc = 0; m_ovf = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rc = 2'($urandom_range(0, 2));
            ra = 8'($urandom);
            rb = 8'($urandom);
            er = model_step(rc, ra, rb);
            if (rc == 2'b10) begin
                pulse_cmd(rc, ra);
                tick;
            end else begin
                do_txn($sformatf("rand%0d", i), rc, ra, rb, er);
            end
            chk($sformatf("rand%0d ovf", i), {31'b0, ovf[0]}, {31'b0, m_ovf});
        end

        // backpressure with stray din strobes in OUT_LO
        dout_ready = 1'b0;
        pulse_cmd(2'b00, 8'hFF);
        din = 8'hFF; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        lat = 0;
        while (!dv[0] && lat < 40) begin
            tick;
            lat++;
        end
        chk("bp latency", lat, 2);
        for (int k = 0; k < 5; k++) begin
            din = 8'($urandom); cmd = 2'($urandom_range(0, 3)); din_valid = 1'b1;
            tick;
            chk($sformatf("bp hold%0d", k), {23'b0, dv[0], dout[0]}, {23'b0, 1'b1, 8'h01});
        end
        din_valid = 1'b0; cmd = 2'b00;
        chk("bp operands", {16'h0, mul_a[0], mul_b[0]}, 32'h0000FFFF);
        dout_ready = 1'b1;
        chk("bp lo", {23'b0, dv[0], dout[0]}, {23'b0, 1'b1, 8'h01});
        tick;
        chk("bp hi", {23'b0, dv[0], dout[0]}, {23'b0, 1'b1, 8'hFE});
        tick;
        chk("bp idle", {30'b0, dv[0], busy[0]}, 0);

        // make ovf sticky-high, then reset in WAIT
        pulse_cmd(2'b10, 8'h00);
        do_txn("pre ovf1", 2'b01, 8'hFF, 8'hFF, 16'hFE01);
        do_txn("pre ovf2", 2'b01, 8'hFF, 8'hFF, 16'hFC02);
        chk("pre ovf", {31'b0, ovf[0]}, 1);
        pulse_cmd(2'b00, 8'h03);
        din = 8'h05; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        chk("in wait", {31'b0, busy[0]}, 1);
        rst = 1'b1;
        #1;
        chk("mid reset", {dout[0], 5'b0, dv[0], busy[0], ovf[0], mul_a[0], mul_b[0]}, 32'h0);
        tick;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen = seen | dv[0] | busy[0];
            tick;
        end
        chk("no partial output", {31'b0, seen}, 0);
        do_txn("post reset", 2'b00, 8'h03, 8'h05, 16'h000F);

        // latency sweep across all instances
        for (int r = 0; r < 3; r++) begin
            rst = 1'b1;
            tick;
            rst = 1'b0;
            tick;
            ra = 8'($urandom);
            rb = 8'($urandom);
            er = model_step(2'b00, ra, rb);
            pulse_cmd(2'b00, ra);
            din = rb; din_valid = 1'b1;
            tick;
            din_valid = 1'b0;
            for (int g = 0; g < NDUT; g++) begin
                first[g] = -1; lo[g] = 8'h00; hi[g] = 8'h00;
            end
            for (int t = 1; t <= 22; t++) begin
                tick;
                for (int g = 0; g < NDUT; g++) begin
                    if (dv[g]) begin
                        if (first[g] < 0) begin
                            first[g] = t;
                            lo[g] = dout[g];
                        end else if (t == first[g] + 1) begin
                            hi[g] = dout[g];
                        end
                    end
                end
            end
            for (int g = 0; g < NDUT; g++) begin
                chk($sformatf("sweep%0d lat%0d latency", r, lat_tab[g]), first[g], lat_tab[g]);
                chk($sformatf("sweep%0d lat%0d product", r, lat_tab[g]), {16'h0, hi[g], lo[g]}, {16'h0, er});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/braun_mul_seq.md
# braun_mul_seq

Byte-serial sequencer for the 8x8 Braun array multiplier. It collects two 8-bit operands and a command from an 8-bit pin bus, drives the array, and waits a fixed settling latency. It then captures the 16-bit product, or a running 16-bit multiply-accumulate, and returns the result as two bytes over a valid/ready output. It sits inside the TinyTapeout top between the dedicated pins and the combinational array.

## Interface
- MUL_LAT, default 2: number of cycles the array output is allowed to settle after operands change; legal range 1..15.
- clk  in  1  system clock; all registers on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  8  operand/command byte bus.
- din_valid  in  1  byte strobe; sampled every cycle in IDLE and LOAD_B.
- cmd  in  2  command, sampled with the first byte: 00 MUL, 01 MAC, 10 CLR, 11 reserved.
- mul_a  out  8  operand A to the array (registered).
- mul_b  out  8  operand B to the array (registered).
- mul_p  in  16  product from the array.
- dout  out  8  result byte.
- dout_valid  out  1  dout holds a valid byte.
- dout_ready  in  1  consumer accepts dout this cycle.
- busy  out  1  high whenever state != IDLE.
- ovf  out  1  sticky accumulator carry-out.

## Operation
- States: IDLE, LOAD_B, WAIT, OUT_LO, OUT_HI.
- IDLE:
  - din_valid with cmd=00/01: mul_a <= din, op <= cmd, go to LOAD_B.
  - din_valid with cmd=10: acc <= 0 and ovf <= 0, stay in IDLE, no output.
  - din_valid with cmd=11: byte discarded, stay in IDLE.
- LOAD_B: din_valid: mul_b <= din, cnt <= MUL_LAT-1, go to WAIT. Without din_valid, hold in LOAD_B indefinitely.
- WAIT: din is ignored. If cnt==0, capture the result and go to OUT_LO; otherwise cnt decrements.
- Result capture:
  - MUL: res <= mul_p; acc unchanged.
  - MAC: {c,sum} = acc + mul_p as a 17-bit add; acc <= sum, res <= sum, ovf <= ovf | c. The sum wraps modulo 2^16.
- OUT_LO: dout = res[7:0], dout_valid=1. On dout_ready, go to OUT_HI.
- OUT_HI: dout = res[15:8], dout_valid=1. On dout_ready, go to IDLE.
- dout_valid is 0 in IDLE, LOAD_B and WAIT; dout is 0 there.
- din_valid in WAIT, OUT_LO or OUT_HI is ignored and produces no side effects. Operands must not be queued.
- mul_a and mul_b hold their last values after the transaction, so the array stays quiet.
- ovf clears only on reset or CLR.
- The accumulator is 16 bits. MAC products are unsigned and no saturation is applied.

## Timing
- Reset (async assert, sync-safe deassert by integration): state=IDLE, mul_a=mul_b=0, acc=res=0, cnt=0. Outputs reset to dout=0, dout_valid=0, busy=0, ovf=0.
- Reset asserted in any state aborts the transaction. No partial output follows.
- The edge that captures B is E0. The result is captured at edge E(MUL_LAT), and dout_valid is high in the cycle after it. mul_p therefore has MUL_LAT full cycles of stable operands.
- With ready held high, dout_valid stays high for exactly 2 cycles. busy falls one cycle after the high byte is accepted.
- The minimum transaction period is 2 + MUL_LAT + 2 cycles.
- Under backpressure, dout and dout_valid hold stable until dout_ready is seen. A byte transfers on any cycle with valid & ready.
- A new A byte is accepted in the first IDLE cycle after the OUT_HI handshake.
- dout_ready while dout_valid=0 has no effect.

## Test plan
- Reset, then MUL 0xFF x 0xFF with MUL_LAT=2 and ready high:
  - dout_valid rises 3 cycles after the A byte edge + 1 (i.e. the cycle after E2).
  - dout=0x01, then 0xFE; busy falls afterwards.
- CLR, then MAC 0x10 x 0x10 -> bytes 0x00,0x01. Next MAC 0x80 x 0x80 -> acc 0x4100, bytes 0x00,0x41, ovf=0.
- Overflow:
  - CLR, then MAC 0xFF x 0xFF twice -> second result 0xFC02, bytes 0x02,0xFC, ovf=1.
  - A following MUL 0x02 x 0x03 -> 0x06,0x00 with ovf still 1. CLR then drops ovf to 0.
- Backpressure: hold dout_ready low 5 cycles in OUT_LO, with din_valid pulses meanwhile:
  - dout stays 0x01 with valid high; the extra din bytes are ignored.
  - Release gives 0x01 then 0xFE.
- Reset mid-operation and reserved command:
  - Assert rst in WAIT -> all outputs 0 immediately; a fresh MUL 0x03 x 0x05 then returns 0x0F,0x00.
  - cmd=11 with din_valid in IDLE -> busy stays 0 and no output.
- MUL_LAT sweep (1, 4, 15): the first dout_valid cycle is exactly MUL_LAT+1 cycles after the B capture edge, with a correct product for random operands against a reference model.
